// File: rtl/output_display.sv
// output_display: shows each 8-bit OUT value as unsigned decimal on a
// 3-digit multiplexed 7-segment display. A sequential double-dabble
// converter builds the BCD digits, a one-deep pending slot holds the latest
// value that arrives mid-conversion, and a refresh counter scans the digits.
module output_display #(
    parameter int unsigned REFRESH_DIV      = 13500,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value,
    input  logic        value_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  digit_en
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int unsigned   CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]    DIG_OFF  = DIGIT_ACTIVE_LOW ? 3'b111 : 3'b000;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after doubling, so pre-add 3 to carry into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    state_e      state_q,    state_d;
    logic [7:0]  bin_q,      bin_d;
    logic [11:0] work_q,     work_d;
    logic [2:0]  shcnt_q,    shcnt_d;
    logic [7:0]  pend_q,     pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [11:0] bcd_q,      bcd_d;
    logic [11:0] work_adj;

    // Next-state logic for the converter FSM, shift datapath and pending slot.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        bin_d      = bin_q;
        work_d     = work_q;
        shcnt_d    = shcnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bcd_d      = bcd_q;
        work_adj   = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};

        case (state_q)
            ST_IDLE: begin
                // A fresh strobe beats the pending value, which is then stale.
                if (value_valid) begin
                    bin_d      = value;
                    work_d     = '0;
                    shcnt_d    = '0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_SHIFT;
                end else if (pend_vld_q) begin
                    bin_d      = pend_q;
                    work_d     = '0;
                    shcnt_d    = '0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {work_d, bin_d} = {work_adj, bin_q} << 1;
                shcnt_d         = shcnt_q + 3'd1;
                if (shcnt_q == 3'd7) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                bcd_d   = work_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes during a conversion park in the pending slot; latest wins.
        if (value_valid && (state_q != ST_IDLE)) begin
            pend_d     = value;
            pend_vld_d = 1'b1;
        end
    end

    // Converter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            shcnt_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would create ordering races.
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            shcnt_q    <= shcnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bcd_q      <= bcd_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       idx_q,     idx_d;
    logic [6:0]       seg_q,     seg_d;
    logic [2:0]       den_q,     den_d;
    logic [3:0]       cur_digit;
    logic             cur_blank;
    logic [2:0]       cur_onehot;
    logic [6:0]       seg_raw;

    // Refresh counter and digit index: advance the slot every REFRESH_DIV cycles.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            idx_d     = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
        end
    end

    // Segment/digit select for the current slot, with leading-zero blanking.
    always_comb begin
        cur_digit  = 4'd0;
        cur_blank  = 1'b1;
        cur_onehot = 3'b000;
        case (idx_q)
            2'd0: begin
                cur_digit  = bcd_q[3:0];
                cur_blank  = 1'b0;
                cur_onehot = 3'b001;
            end
            2'd1: begin
                cur_digit  = bcd_q[7:4];
                cur_blank  = (bcd_q[11:4] == 8'd0);
                cur_onehot = 3'b010;
            end
            2'd2: begin
                cur_digit  = bcd_q[11:8];
                cur_blank  = (bcd_q[11:8] == 4'd0);
                cur_onehot = 3'b100;
            end
            default: begin
                cur_digit  = 4'd0;
                cur_blank  = 1'b1;
                cur_onehot = 3'b000;
            end
        endcase
        seg_raw = cur_blank ? 7'h00 : seg_decode(cur_digit);
        seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        den_d   = DIGIT_ACTIVE_LOW ? ~cur_onehot : cur_onehot;
    end

    // Scan registers; seg/digit_en lag the index by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
            seg_q     <= SEG_OFF;
            den_q     <= DIG_OFF;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            den_q     <= den_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign bcd      = bcd_q;
    assign seg      = seg_q;
    assign digit_en = den_q;

endmodule

// File: tb/tb_output_display.sv
// Directed testbench for output_display: conversion latency, blanking,
// pending-slot behaviour, reset handling and scan cadence.
module tb_output_display;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  value = 8'd0;
    logic        value_valid = 1'b0;

    logic        busy,   busy_s;
    logic [11:0] bcd,    bcd_s;
    logic [6:0]  seg,    seg_s;
    logic [2:0]  den,    den_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_display #(
        .REFRESH_DIV     (DIV),
        .SEG_ACTIVE_LOW  (1'b1),
        .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .value_valid(value_valid),
        .busy       (busy),
        .bcd        (bcd),
        .seg        (seg),
        .digit_en   (den)
    );

    output_display #(
        .REFRESH_DIV     (DIV),
        .SEG_ACTIVE_LOW  (1'b1),
        .DIGIT_ACTIVE_LOW(1'b0)
    ) dut_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .value_valid(value_valid),
        .busy       (busy_s),
        .bcd        (bcd_s),
        .seg        (seg_s),
        .digit_en   (den_s)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance past the next rising edge; all driving and sampling happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; on return edge E has sampled it.
    task automatic strobe(input logic [7:0] v);
        value       = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    // Counts busy samples from just after E; pre is bcd sampled just after E+8.
    task automatic run_until_idle(output int n, output logic [11:0] pre);
        n   = 0;
        pre = 'x;
        while (busy && n < 30) begin
            n++;
            if (n == 9) pre = bcd;
            tick();
        end
    endtask

    // Records the segment pattern shown in each active-low digit slot.
    task automatic capture_scan(output logic [6:0] s_ones, output logic [6:0] s_tens,
                                output logic [6:0] s_hund);
        s_ones = 'x;
        s_tens = 'x;
        s_hund = 'x;
        repeat (3 * DIV + 2) begin
            case (den)
                3'b110:  s_ones = seg;
                3'b101:  s_tens = seg;
                3'b011:  s_hund = seg;
                default: ;
            endcase
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        value_valid = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", bcd); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
        checks++; if (den !== 3'b111) begin errors++; $display("FAIL reset_digit_en: got %b expected 111", den); end
        checks++; if (den_s !== 3'b000) begin errors++; $display("FAIL reset_digit_en_hi: got %b expected 000", den_s); end
        rst_n = 1'b1;
        tick();
        checks++; if (seg !== 7'h40) begin errors++; $display("FAIL reset_first_seg: got %h expected 40", seg); end
        checks++; if (den !== 3'b110) begin errors++; $display("FAIL reset_first_digit: got %b expected 110", den); end
        checks++; if (den_s !== 3'b001) begin errors++; $display("FAIL reset_first_digit_hi: got %b expected 001", den_s); end
    endtask

    task automatic test_single_conversion();
        int         n;
        logic [11:0] pre;
        logic [6:0] so, st, sh;
        strobe(8'hFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        run_until_idle(n, pre);
        checks++; if (n != 9) begin errors++; $display("FAIL single_busy_len: got %0d expected 9", n); end
        checks++; if (pre !== 12'h000) begin errors++; $display("FAIL single_bcd_early: got %h expected 000", pre); end
        checks++; if (bcd !== 12'h255) begin errors++; $display("FAIL single_bcd: got %h expected 255", bcd); end
        capture_scan(so, st, sh);
        checks++; if (so !== 7'h12) begin errors++; $display("FAIL single_seg_ones: got %h expected 12", so); end
        checks++; if (st !== 7'h12) begin errors++; $display("FAIL single_seg_tens: got %h expected 12", st); end
        checks++; if (sh !== 7'h24) begin errors++; $display("FAIL single_seg_hund: got %h expected 24", sh); end
    endtask

    task automatic test_blanking();
        int         n;
        logic [11:0] pre;
        logic [6:0] so, st, sh;
        strobe(8'd7);
        run_until_idle(n, pre);
        checks++; if (bcd !== 12'h007) begin errors++; $display("FAIL blank7_bcd: got %h expected 007", bcd); end
        capture_scan(so, st, sh);
        checks++; if (so !== 7'h78) begin errors++; $display("FAIL blank7_ones: got %h expected 78", so); end
        checks++; if (st !== 7'h7F) begin errors++; $display("FAIL blank7_tens: got %h expected 7f", st); end
        checks++; if (sh !== 7'h7F) begin errors++; $display("FAIL blank7_hund: got %h expected 7f", sh); end
        strobe(8'd40);
        run_until_idle(n, pre);
        checks++; if (bcd !== 12'h040) begin errors++; $display("FAIL blank40_bcd: got %h expected 040", bcd); end
        capture_scan(so, st, sh);
        checks++; if (so !== 7'h40) begin errors++; $display("FAIL blank40_ones: got %h expected 40", so); end
        checks++; if (st !== 7'h19) begin errors++; $display("FAIL blank40_tens: got %h expected 19", st); end
        checks++; if (sh !== 7'h7F) begin errors++; $display("FAIL blank40_hund: got %h expected 7f", sh); end
    endtask

    task automatic test_pending_latest();
        int busy_seen;
        strobe(8'd100);                                      // edge E
        tick();                                              // E+1
        value = 8'd17;  value_valid = 1'b1; tick(); value_valid = 1'b0;   // E+2
        tick(); tick();                                      // E+4
        value = 8'd200; value_valid = 1'b1; tick(); value_valid = 1'b0;   // E+5
        repeat (3) tick();                                   // E+8
        checks++; if (bcd !== 12'h040) begin errors++; $display("FAIL pend_bcd_e8: got %h expected 040", bcd); end
        tick();                                              // E+9
        checks++; if (bcd !== 12'h100) begin errors++; $display("FAIL pend_bcd_e9: got %h expected 100", bcd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_busy_e9: got %b expected 0", busy); end
        tick();                                              // E+10
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_restart_e10: got %b expected 1", busy); end
        repeat (8) tick();                                   // E+18
        checks++; if (bcd !== 12'h100) begin errors++; $display("FAIL pend_bcd_e18: got %h expected 100", bcd); end
        tick();                                              // E+19
        checks++; if (bcd !== 12'h200) begin errors++; $display("FAIL pend_bcd_e19: got %h expected 200", bcd); end
        busy_seen = 0;
        repeat (20) begin tick(); if (busy) busy_seen++; end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL pend_extra_conv: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (bcd !== 12'h200) begin errors++; $display("FAIL pend_final_bcd: got %h expected 200", bcd); end
    endtask

    task automatic test_back_to_back();
        int busy_seen;
        strobe(8'd12);                                       // edge E
        tick();                                              // E+1
        value = 8'd34; value_valid = 1'b1; tick(); value_valid = 1'b0;    // E+2
        repeat (7) tick();                                   // E+9
        checks++; if (bcd !== 12'h012) begin errors++; $display("FAIL b2b_first: got %h expected 012", bcd); end
        value = 8'd56; value_valid = 1'b1; tick(); value_valid = 1'b0;    // E+10, beats pending 34
        repeat (8) tick();                                   // E+18
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e18: got %b expected 1", busy); end
        tick();                                              // E+19
        checks++; if (bcd !== 12'h056) begin errors++; $display("FAIL b2b_priority: got %h expected 056", bcd); end
        busy_seen = 0;
        repeat (15) begin tick(); if (busy) busy_seen++; end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL b2b_pending_cleared: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (bcd !== 12'h056) begin errors++; $display("FAIL b2b_final_bcd: got %h expected 056", bcd); end
    endtask

    task automatic test_reset_mid_conversion();
        int          n, busy_seen;
        logic [11:0] pre;
        logic [6:0]  so, st, sh;
        strobe(8'd123);                                      // edge E
        tick();                                              // E+1
        value = 8'd55; value_valid = 1'b1; tick(); value_valid = 1'b0;    // E+2, into pending
        tick(); tick();                                      // E+4
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL midrst_bcd: got %h expected 000", bcd); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h expected 7f", seg); end
        tick();
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (15) begin tick(); if (busy) busy_seen++; end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL midrst_pending_kept: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL midrst_bcd_hold: got %h expected 000", bcd); end
        strobe(8'd9);
        run_until_idle(n, pre);
        checks++; if (n != 9) begin errors++; $display("FAIL midrst_busy_len: got %0d expected 9", n); end
        checks++; if (bcd !== 12'h009) begin errors++; $display("FAIL midrst_new_bcd: got %h expected 009", bcd); end
        capture_scan(so, st, sh);
        checks++; if (so !== 7'h10) begin errors++; $display("FAIL midrst_ones: got %h expected 10", so); end
        checks++; if (st !== 7'h7F) begin errors++; $display("FAIL midrst_tens: got %h expected 7f", st); end
        checks++; if (sh !== 7'h7F) begin errors++; $display("FAIL midrst_hund: got %h expected 7f", sh); end
    endtask

    task automatic test_scan_cadence();
        logic [2:0] prev;
        int         k, run, nonhot;
        prev = den_s;
        k    = 0;
        while (den_s == prev && k < 3 * DIV) begin tick(); k++; end
        checks++; if (den_s == prev) begin errors++; $display("FAIL scan_start: digit_en stuck at %b", den_s); end
        prev   = den_s;
        nonhot = 0;
        for (int t = 0; t < 9; t++) begin
            run = 0;
            while (den_s == prev && run < 3 * DIV) begin
                if (!$onehot(den_s)) nonhot++;
                run++;
                tick();
            end
            checks++; if (run != DIV) begin errors++; $display("FAIL scan_hold: %b held %0d cycles expected %0d", prev, run, DIV); end
            checks++; if (den_s !== {prev[1:0], prev[2]}) begin errors++; $display("FAIL scan_order: after %b got %b expected %b", prev, den_s, {prev[1:0], prev[2]}); end
            prev = den_s;
        end
        checks++; if (nonhot != 0) begin errors++; $display("FAIL scan_onehot: got %0d non-one-hot samples expected 0", nonhot); end
    endtask

    initial begin
        test_reset();
        test_single_conversion();
        test_blanking();
        test_pending_latest();
        test_back_to_back();
        test_reset_mid_conversion();
        test_scan_cadence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_display.md
# output_display

Downstream consumer of the CPU output register: it takes each 8-bit value written by an OUT instruction and shows it as an unsigned decimal number (0–255) on a 3-digit multiplexed 7-segment display. A sequential double-dabble converter produces the BCD digits, a one-deep pending slot absorbs values that arrive during conversion, and a refresh counter scans the digits. It runs on the board clock `clk`, not the divided CPU clock.

## Interface
- `REFRESH_DIV`, default 13500: `clk` cycles per digit slot; legal values are 2 and up.
- `SEG_ACTIVE_LOW`, default 1: when 1, `seg` is inverted (a lit segment drives 0).
- `DIGIT_ACTIVE_LOW`, default 1: when 1, `digit_en` is inverted (the selected digit drives 0).

Ports:
- `clk`  in  1  board clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `value`  in  8  value to display (the CPU output register).
- `value_valid`  in  1  one-cycle strobe; `value` is sampled when this is high.
- `busy`  out  1  high while a conversion is in progress.
- `bcd`  out  12  committed digits {hundreds, tens, ones}, for debug and verification.
- `seg`  out  7  segment pattern {g,f,e,d,c,b,a}.
- `digit_en`  out  3  one-hot digit select; bit 0 = ones, bit 2 = hundreds.

## Operation
- FSM states are IDLE, SHIFT and COMMIT.
- **IDLE**
  - If `value_valid` is high: load `value` into the shift register, clear pending, go to SHIFT.
  - Else if pending is valid: load the pending value, clear pending, go to SHIFT.
- **SHIFT**
  - Runs for exactly 8 cycles, tracked by a 3-bit counter.
  - Each cycle, first add 3 to every BCD nibble that is 5 or more, then shift {bcd_work, bin} left by 1.
  - After the 8th shift, go to COMMIT.
- **COMMIT**
  - Copy bcd_work into `bcd`, then go to IDLE.
- **Pending slot**
  - A `value_valid` seen in SHIFT or COMMIT writes the pending register and sets pending valid.
  - A later strobe overwrites it, so the latest value wins. Earlier values are dropped.
- **busy** is high in SHIFT and COMMIT, low in IDLE.
- **Leading-zero blanking**
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when hundreds and tens are both 0.
  - Ones digit is never blank.
  - A blanked digit is still scanned, with all segments off.
- **Segment codes** (active-high, before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- **Width rules**
  - The input is always treated as unsigned, so 255 displays as "255".
  - No nibble of `bcd` ever exceeds 9.

## Timing
- **Reset** (async, takes effect immediately) sets:
  - state to IDLE and pending valid to 0;
  - `busy` = 0 and `bcd` = 000;
  - refresh counter = 0 and digit index = 0;
  - `seg` to all off (7F when `SEG_ACTIVE_LOW`);
  - `digit_en` to none selected (3'b111 when `DIGIT_ACTIVE_LOW`).
- **Conversion latency**
  - Edge E samples the strobe in IDLE.
  - `busy` goes high after edge E.
  - `bcd` updates on edge E+9 and `busy` goes low after edge E+9.
- **Back-to-back conversion**
  - A strobe during busy is picked up from pending in IDLE at E+10, so its conversion starts at edge E+10.
  - A strobe arriving in IDLE takes priority over pending; pending is cleared in that case.
- **Scan**
  - The refresh counter runs 0..`REFRESH_DIV`-1.
  - On wrap, the digit index advances 0→1→2→0.
  - `seg` and `digit_en` are registered: they reflect the new index and the current `bcd` one cycle after the index changes.
  - Each digit is enabled for exactly `REFRESH_DIV` cycles.
- **Display update**: a `bcd` change appears on the next registered `seg` update. There is no tearing within a slot beyond one cycle.
- **Reset mid-conversion** discards the partial result and the pending value. `bcd` reads 000 until a new conversion completes.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles, release.
  - Required: `busy`=0, `bcd`=000, `seg`=7F and `digit_en`=111 while in reset.
  - After release, the ones slot shows `seg`=~3F=40.
- **Single conversion**: strobe `value`=8'hFF.
  - Required: `busy` high for 9 cycles, `bcd`=12'h255 at E+9.
  - Digits scan as 5, 5, 2: `seg`=~6D=12, ~6D=12, ~5B=24.
- **Blanking**: strobe 7.
  - Required: `bcd`=007.
  - Ones slot shows ~07=78; tens and hundreds slots show `seg`=7F while their `digit_en` bit is active.
  - Strobe 40: `bcd`=040, hundreds blank, tens shows ~66=19.
- **Pending, latest wins**: strobe 100 at E, 17 at E+2, 200 at E+5.
  - Required: `bcd`=100 at E+9, then 200 at E+19.
  - 17 is never committed.
- **Reset mid-conversion**: strobe 123, assert `rst_n` low at E+4 for 1 cycle.
  - Required: `busy`=0 immediately and `bcd` stays 000.
  - A new strobe of 9 yields `bcd`=009.
- **Scan cadence** with `REFRESH_DIV`=4, `DIGIT_ACTIVE_LOW`=0:
  - `digit_en` cycles 001→010→100→001.
  - Each value is held exactly 4 cycles, with exactly one bit set at all times after the first wrap.
